// File: rtl/fifo_uart_pkg.sv
// Shared FSM state encodings and UART line levels for fifo_uart_tx.
// FIFO_UART_TX_PARITY_EN adds the PARITY state.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_STOP   = 3'd5
`ifdef FIFO_UART_TX_PARITY_EN
        , ST_PARITY = 3'd6
`endif
    } state_t;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a synchronous FIFO and its single consumer.
interface fifo_uart_tx_if #(
    parameter int DWIDTH = 8
);
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_data;
    logic              fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en
    );
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_end on the last cycle.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = !restart && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and serialises each as an 8N1 UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy
);
    localparam int IW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DWIDTH - 1);

    state_t            state, state_next;
    logic [DWIDTH-1:0] shift_reg, shift_next;
    logic [IW-1:0]     bit_idx, bit_idx_next;
    logic              tx_next;
    logic              restart;
    logic              bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              parity_q, parity_next;
`endif

    // Hold the baud counter at zero until the start bit so START is a full bit long.
    assign restart = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_WAIT);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .bit_end (bit_end)
    );

    assign fifo.fifo_rd_en = (state == ST_FETCH);
    assign busy            = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx        <= UART_IDLE;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            tx        <= tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next  = parity_q;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo.fifo_empty) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                shift_next = fifo.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_next = ^fifo.fifo_data;
`endif
                state_next = ST_START;
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_next = fifo.fifo_empty ? ST_IDLE : ST_FETCH;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // tx is registered from the next state so the pin never glitches.
        tx_next = UART_IDLE;
        case (state_next)
            ST_START: tx_next = UART_START;
            ST_DATA:  tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_next = parity_next;
`endif
            default:  tx_next = UART_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, frame-position reference model, vectors.
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int FB  = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int TOTAL = 2 + FB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;

    fifo_uart_tx_if #(.DWIDTH(DW)) ifc ();

    fifo_uart_tx #(
        .DWIDTH       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fifo (ifc),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO with one-cycle registered read data.
    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic [7:0] fifo_q = 8'd0;
    logic [7:0] exp_q [$];

    assign ifc.fifo_empty = (wr_ptr == rd_ptr);
    assign ifc.fifo_data  = fifo_q;

    always @(posedge clk) begin
        if (ifc.fifo_rd_en) begin
            chk("no_underflow_pop", ifc.fifo_empty, 1'b0);
            if (wr_ptr != rd_ptr) begin
                fifo_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 8'd1;
            end
        end
    end

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr      = wr_ptr + 8'd1;
        exp_q.push_back(v);
    endtask

    // Reference model: position (in cycles) since the pop request of the current transfer.
    bit         m_act  = 1'b0;
    int         m_pos  = 0;
    logic [7:0] m_byte = 8'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0;
            m_pos <= 0;
        end else if (!m_act) begin
            if (!ifc.fifo_empty) begin
                m_act <= 1'b1;
                m_pos <= 0;
            end
        end else if (m_pos == TOTAL - 1) begin
            if (!ifc.fifo_empty) m_pos <= 0;
            else                 m_act <= 1'b0;
        end else begin
            m_pos <= m_pos + 1;
            if (m_pos == 0 && exp_q.size() > 0) m_byte <= exp_q.pop_front();
        end
    end

    function automatic logic exp_tx(input bit act, input int pos, input logic [7:0] b);
        int slot;
        if (!act || pos < 2) return 1'b1;
        slot = (pos - 2) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return b[slot-1];
        if (PAR && slot == DW + 1) return ^b;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        chk("model_tx",    tx,             exp_tx(m_act, m_pos, m_byte));
        chk("model_rd_en", ifc.fifo_rd_en, m_act && (m_pos == 0));
        chk("model_busy",  busy,           m_act);
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // {stop, data, start}, bit 0 sent first
        logic       par;
    } vec_t;

    vec_t vecs [7];

    task automatic wait_pop();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ifc.fifo_rd_en) seen = 1'b1;
        end
        chk("pop_seen", seen, 1'b1);
    endtask

    // Entered at the negedge of the pop cycle; ends at the last stop-bit cycle.
    task automatic check_frame(input vec_t v, input int push_slot, input logic [7:0] push_val);
        logic e;
        @(negedge clk);
        chk("wait_tx_high", tx, 1'b1);
        chk("wait_rd_en_low", ifc.fifo_rd_en, 1'b0);
        for (int s = 0; s < FB; s++) begin
            if (s == FB - 1)             e = 1'b1;
            else if (PAR && s == FB - 2) e = v.par;
            else                         e = v.frame[s];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (s == push_slot && c == 0) push(push_val);
                chk("frame_bit", tx, e);
                chk("frame_busy", busy, 1'b1);
                chk("no_pop_mid_frame", ifc.fifo_rd_en, 1'b0);
            end
        end
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        chk("busy_falls", busy, 1'b0);
        chk("idle_tx", tx, 1'b1);
        chk("idle_rd_en", ifc.fifo_rd_en, 1'b0);
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_rd_en", ifc.fifo_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        bit   done;
        vec_t v;

        vecs[0] = '{8'hA5, 10'h34A, 1'b0};
        vecs[1] = '{8'h00, 10'h200, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[3] = '{8'h3C, 10'h278, 1'b0};
        vecs[4] = '{8'h07, 10'h20E, 1'b1};
        vecs[5] = '{8'h03, 10'h206, 1'b0};
        vecs[6] = '{8'h80, 10'h300, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_rd_en", ifc.fifo_rd_en, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            push(vecs[i].data);
            wait_pop();
            check_frame(vecs[i], -1, 8'h00);
            check_idle_after();
        end

        // Back-to-back: two idle-high cycles between frames, busy held.
        push(8'h00);
        push(8'hFF);
        wait_pop();
        check_frame(vecs[1], -1, 8'h00);
        @(negedge clk);
        chk("b2b_pop", ifc.fifo_rd_en, 1'b1);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_gap_tx", tx, 1'b1);
        check_frame(vecs[2], -1, 8'h00);
        check_idle_after();

        // FIFO empty during the frame, write lands in DATA: pop only after STOP.
        push(8'h5A);
        wait_pop();
        v = '{8'h5A, 10'h2B4, 1'b0};
        check_frame(v, 3, 8'h81);
        @(negedge clk);
        chk("pop_at_stop_end", ifc.fifo_rd_en, 1'b1);
        v = '{8'h81, 10'h302, 1'b0};
        check_frame(v, -1, 8'h00);
        check_idle_after();

        // Reset in DATA bit 3 of 0x3C: byte dropped, next word sent.
        push(8'h3C);
        push(8'h99);
        wait_pop();
        repeat (1 + CPB + 3 * CPB + 1) @(negedge clk);
        reset_pulse();
        wait_pop();
        v = '{8'h99, 10'h332, 1'b0};
        check_frame(v, -1, 8'h00);
        check_idle_after();

        // Reset mid-frame with nothing left: line stays idle.
        push(8'h55);
        wait_pop();
        repeat (10) @(negedge clk);
        reset_pulse();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("post_rst_tx", tx, 1'b1);
            chk("post_rst_rd_en", ifc.fifo_rd_en, 1'b0);
        end

        // Random pushes and occasional resets against the reference model.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (8'(wr_ptr - rd_ptr) < 8'd3 && $urandom_range(0, 9) == 0) push(8'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end

        done = 1'b0;
        for (int i = 0; i < 5 * TOTAL && !done; i++) begin
            @(negedge clk);
            if (ifc.fifo_empty && !busy) done = 1'b1;
        end
        chk("drain_done", done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drains bytes from the read side of a synchronous FIFO and serializes each one as an 8N1 UART frame on `tx`.
- It is the consumer at the far end of the FIFO's `rd_en`/`empty`/`data_out` interface. It pops one word per frame, honouring the FIFO's one-cycle registered read latency.
- It sits between the TX FIFO and the pad and is the only reader of that FIFO.

Parameters:
- DWIDTH, 8: data bits per frame; must match the FIFO data width.
- CLKS_PER_BIT, 16: clk cycles per UART bit; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DWIDTH  FIFO registered read data; valid the cycle after the rd_en edge.
- fifo_rd_en  output  1  pop request to the FIFO; single-cycle pulse.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the pop until the end of the stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; tx=1, fifo_rd_en=0, busy=0.
  - Baud counter and bit index are cleared.
- States: IDLE, FETCH, WAIT, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE:
  - tx=1, busy=0.
  - If fifo_empty=0, go to FETCH next cycle.
- FETCH (1 cycle):
  - fifo_rd_en=1, busy=1.
  - The FIFO pops at the edge ending FETCH.
- WAIT (1 cycle):
  - fifo_rd_en=0.
  - fifo_data is valid now and is captured into shift_reg at the edge ending WAIT.
  - Go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - DWIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
  - shift_reg shifts right at each bit end; the bit index counts 0..DWIDTH-1.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle of STOP:
  - if fifo_empty=0, go directly to FETCH (busy stays 1);
  - otherwise go to IDLE.
- Bit timing:
  - The baud counter is $clog2(CLKS_PER_BIT) wide and counts 0..CLKS_PER_BIT-1.
  - It reloads to 0 on every bit boundary and on entry to START.
- Frame length:
  - 1+DWIDTH+1 bits, i.e. (DWIDTH+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
  - Inter-frame gap when back-to-back: exactly 2 cycles of tx=1 (FETCH+WAIT).
- Boundary conditions:
  - fifo_rd_en never asserts while fifo_empty=1, so there is no underflow pop.
  - fifo_empty is sampled only in IDLE and at the end of STOP; changes mid-frame are ignored.
  - The FIFO filling mid-frame has no effect until STOP completes.
- tx is driven from a register, so it is glitch-free.
- fifo_rd_en is decoded from the state register (FETCH).
- Reset mid-frame:
  - tx returns to 1 asynchronously and the in-flight byte is discarded (not retried).
  - After release, a pop occurs only if fifo_empty=0.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx = XOR of the captured data word (even parity).
  - Frame length is (DWIDTH+3)*CLKS_PER_BIT.
- Undefined:
  - No PARITY state or logic; frame is 8N1, (DWIDTH+2)*CLKS_PER_BIT.

Decomposition:
- Shared package/include fifo_uart_pkg:
  - state encodings (3-bit localparams ST_IDLE..ST_STOP, ST_PARITY);
  - line levels UART_IDLE=1, UART_START=0.
- One natural sub-module, uart_baud_gen:
  - CLKS_PER_BIT counter with a restart input;
  - bit_end pulse on the last cycle of each bit.

Test Plan (CLKS_PER_BIT=4, DWIDTH=8, feature off unless noted):
- Reset asserted mid-operation -> immediately tx=1, fifo_rd_en=0, busy=0; with fifo_empty=1 after release, tx stays 1 and rd_en stays 0 for 100 cycles.
- FIFO holds 0xA5 -> one fifo_rd_en pulse.
  - 2 cycles later, tx=0 for 4 cycles.
  - Then data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then stop=1 for 4 cycles; 40-cycle frame.
  - busy falls the cycle after the stop bit.
- FIFO holds 0x00 then 0xFF -> two rd_en pulses; exactly 2 idle-high cycles between frame-1 stop end and frame-2 start; busy stays 1 throughout.
- fifo_empty goes 1 mid-frame and a write arrives during DATA -> the current frame completes unchanged, and the next pop occurs only at the end of STOP.
- Reset asserted during DATA bit 3 of 0x3C -> tx=1 at once; no retry of 0x3C; the next FIFO word is popped after release.
- FIFO_UART_TX_PARITY_EN defined, byte 0x07 -> parity bit tx=1 for 4 cycles before stop; 44-cycle frame. Byte 0x03 -> parity bit 0.
